misao_mem_ctrl: RTL and testbench
=================================

MISAO_MEM_CTRL -- requirements
Module: misao_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, address width in bits.
REQ-002 SHALL have parameter DATA_W, default 8, data width in bits.
REQ-003 SHALL have parameter DEPTH, default 32768, number of words in the backing array.
REQ-004 SHALL have parameter READ_LAT, default 2, read latency in cycles; legal range 1..15.
REQ-005 SHALL have parameter PROT_LIMIT, default 256, first writable address when protection is compiled in.
REQ-006 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port req_rd  input  1  read request.
REQ-009 SHALL have port req_wr  input  1  write request.
REQ-010 SHALL have port req_addr  input  ADDR_W  access address.
REQ-011 SHALL have port req_wdata  input  DATA_W  write data.
REQ-012 SHALL have port req_ready  output  1  controller can accept a request this cycle.
REQ-013 SHALL have port rsp_valid  output  1  one-cycle read-data strobe.
REQ-014 SHALL have port rsp_rdata  output  DATA_W  read data, valid when rsp_valid is high.
REQ-015 SHALL have port err  output  1  one-cycle error pulse.
REQ-016 SHALL have port acc_cnt  output  16  count of accepted accesses.

Function
REQ-017 SHALL accept a request on a rising edge where req_ready=1 and exactly one of req_rd and req_wr is 1.
REQ-018 SHALL use FSM states IDLE, WAIT and RESP; req_ready=1 only in IDLE.
REQ-019 SHALL commit an accepted write to the array on the accept edge, remain in IDLE, and accept back-to-back writes every cycle.
REQ-020 SHALL move from IDLE to WAIT on read accept, load an internal counter with READ_LAT-1, and latch req_addr.
REQ-021 SHALL decrement the counter in WAIT and move to RESP when it is 0; with READ_LAT=1 the FSM SHALL go from IDLE directly to RESP.
REQ-022 SHALL assert rsp_valid for exactly the one RESP cycle, which is READ_LAT cycles after the accept edge, then return to IDLE.
REQ-023 SHALL hold rsp_rdata at its last value outside RESP cycles.
REQ-024 SHALL, when req_rd=1 and req_wr=1 together in IDLE, perform no access, pulse err the next cycle, and leave acc_cnt unchanged.
REQ-025 SHALL treat req_addr >= DEPTH as out of range: a read completes with normal timing, rsp_rdata=0 and err pulsed together with rsp_valid; a write is dropped and err pulses the next cycle.
REQ-026 SHALL increment acc_cnt by 1 per accepted read or write, including out-of-range accesses, wrapping from 0xFFFF to 0x0000.
REQ-027 SHALL ignore req_* while req_ready=0; requests are not queued.
REQ-028 SHALL return the newly written data for a read accepted on the cycle after a write to the same address.

Reset
REQ-029 SHALL, while rst=1, force state=IDLE, counter=0, req_ready=1 after release, rsp_valid=0, rsp_rdata=0, err=0 and acc_cnt=0.
REQ-030 SHALL abort a pending read on reset mid-operation, with no rsp_valid afterwards.
REQ-031 SHALL NOT clear array contents on reset.

Configuration
REQ-032 SHALL, with MISAO_MEM_PROTECT_EN defined, drop in-range writes to addresses < PROT_LIMIT and pulse err the next cycle; such writes are still counted in acc_cnt.
REQ-033 SHALL, without MISAO_MEM_PROTECT_EN, commit all in-range writes, ignore PROT_LIMIT, and add no protection logic.

Verification
REQ-034 SHALL cover: READ_LAT=2, write 0xA5 to 0x0105 then read 0x0105 -> rsp_valid 2 cycles after accept, rdata=0xA5, acc_cnt=2.
REQ-035 SHALL cover: READ_LAT=1, four back-to-back writes to 0x0200..0x0203 then reads -> one write accepted per cycle, each read returns its data 1 cycle after accept, req_ready low for 1 cycle per read.
REQ-036 SHALL cover: req_rd=req_wr=1 at 0x0300 -> err pulse only, no rsp_valid, acc_cnt unchanged; read of 0x7FFF with DEPTH=16384 -> rdata=0x00 with err and rsp_valid together.
REQ-037 SHALL cover: reset asserted one cycle after read accept with READ_LAT=4 -> no rsp_valid, acc_cnt=0, req_ready=1 after release.
REQ-038 SHALL cover: MISAO_MEM_PROTECT_EN defined, write 0x3C to 0x0010 -> err pulse, read 0x0010 returns prior value; build without the macro -> read returns 0x3C.
REQ-039 SHALL cover: 65536 accepted writes from reset -> acc_cnt wraps to 0x0000.

Source files
------------

// File: rtl/misao_mem_ctrl.sv
// misao_mem_ctrl: single-port memory controller with fixed-latency reads and single-cycle writes.
// Latency: writes commit on the accept edge; read data is strobed READ_LAT cycles after the accept edge.
// Backpressure: req_ready is high only in IDLE, and requests presented while it is low are dropped, not queued.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset (clears control state and counters, never the array)
//   req_rd     read request          req_wr    write request
//   req_addr   access address        req_wdata write data
//   req_ready  controller idle and able to take a request this cycle
//   rsp_valid  one-cycle read data strobe; rsp_rdata holds its value between strobes
//   err        one-cycle pulse: rd+wr conflict, out-of-range access, or protected write
//   acc_cnt    16-bit wrapping count of accepted reads and writes
//
// Build option: define MISAO_MEM_PROTECT_EN to reject in-range writes below PROT_LIMIT.
module misao_mem_ctrl #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 32768,
  parameter int READ_LAT   = 2,
  parameter int PROT_LIMIT = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              err,
  output logic [15:0]       acc_cnt
);

  if (READ_LAT < 1 || READ_LAT > 15) begin : g_bad_read_lat
    $error("misao_mem_ctrl: READ_LAT must be in 1..15");
  end
  if (PROT_LIMIT < 0) begin : g_bad_prot_limit
    $error("misao_mem_ctrl: PROT_LIMIT must not be negative");
  end

  localparam int          IDX_W   = $clog2(DEPTH);
  localparam logic [31:0] DEPTH_L = 32'(DEPTH);
  localparam logic [3:0]  LAT_M1  = 4'(READ_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [15:0]       acc_q, acc_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_idle;
  logic              rd_acc;
  logic              wr_acc;
  logic              conflict;
  logic              wr_in_range;
  logic              wr_prot;
  logic              mem_we;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_in_range;
  logic [DATA_W-1:0] rd_word;

  assign in_idle  = (state_q == IDLE);
  assign rd_acc   = in_idle && req_rd && !req_wr;
  assign wr_acc   = in_idle && req_wr && !req_rd;
  assign conflict = in_idle && req_rd && req_wr;

  assign wr_in_range = (32'(req_addr) < DEPTH_L);

`ifdef MISAO_MEM_PROTECT_EN
  localparam logic [31:0] PROT_L = 32'(PROT_LIMIT);
  assign wr_prot = (32'(req_addr) < PROT_L);
`else
  assign wr_prot = 1'b0;
`endif

  assign mem_we = wr_acc && wr_in_range && !wr_prot;

  // With READ_LAT=1 the data is captured on the accept edge itself, before
  // addr_q is loaded, so the live request address is used while in IDLE.
  assign rd_addr     = in_idle ? req_addr : addr_q;
  assign rd_in_range = (32'(rd_addr) < DEPTH_L);
  assign rd_word     = mem[rd_addr[IDX_W-1:0]];

  // Array has no reset: contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[req_addr[IDX_W-1:0]] <= req_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    acc_d   = acc_q;

    unique case (state_q)
      IDLE: begin
        if (conflict) begin
          err_d = 1'b1;
        end else if (wr_acc) begin
          acc_d = acc_q + 16'd1;
          err_d = !wr_in_range || wr_prot;
        end else if (rd_acc) begin
          acc_d  = acc_q + 16'd1;
          addr_d = req_addr;
          if (READ_LAT == 1) begin
            state_d = RESP;
            rdata_d = rd_in_range ? rd_word : '0;
            err_d   = !rd_in_range;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      WAIT: begin
        // Counter holds the remaining WAIT cycles; RESP is entered on the
        // edge where it decrements to zero.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
          rdata_d = rd_in_range ? rd_word : '0;
          err_d   = !rd_in_range;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      acc_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      acc_q   <= acc_d;
    end
  end

  assign req_ready = in_idle;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign err       = err_q;
  assign acc_cnt   = acc_q;

endmodule

// File: tb/tb_misao_mem_ctrl.sv
// tb_misao_mem_ctrl: directed bench for misao_mem_ctrl with three instances
// (READ_LAT=2/DEPTH=16384, READ_LAT=1, READ_LAT=4), each with its own stimulus.
// Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
module tb_misao_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [3];
  logic        rd    [3];
  logic        wr    [3];
  logic [14:0] addr  [3];
  logic [7:0]  wdata [3];
  logic        rdy   [3];
  logic        vld   [3];
  logic [7:0]  rdata [3];
  logic        err   [3];
  logic [15:0] acc   [3];

  int checks = 0;
  int errors = 0;

  logic [7:0] bdat [4] = '{8'h10, 8'h21, 8'h32, 8'h43};

  misao_mem_ctrl #(.ADDR_W(15), .DATA_W(8), .DEPTH(16384), .READ_LAT(2), .PROT_LIMIT(256)) u_lat2 (
    .clk(clk), .rst(rst[0]), .req_rd(rd[0]), .req_wr(wr[0]), .req_addr(addr[0]),
    .req_wdata(wdata[0]), .req_ready(rdy[0]), .rsp_valid(vld[0]), .rsp_rdata(rdata[0]),
    .err(err[0]), .acc_cnt(acc[0])
  );

  misao_mem_ctrl #(.ADDR_W(15), .DATA_W(8), .DEPTH(32768), .READ_LAT(1), .PROT_LIMIT(256)) u_lat1 (
    .clk(clk), .rst(rst[1]), .req_rd(rd[1]), .req_wr(wr[1]), .req_addr(addr[1]),
    .req_wdata(wdata[1]), .req_ready(rdy[1]), .rsp_valid(vld[1]), .rsp_rdata(rdata[1]),
    .err(err[1]), .acc_cnt(acc[1])
  );

  misao_mem_ctrl #(.ADDR_W(15), .DATA_W(8), .DEPTH(32768), .READ_LAT(4), .PROT_LIMIT(256)) u_lat4 (
    .clk(clk), .rst(rst[2]), .req_rd(rd[2]), .req_wr(wr[2]), .req_addr(addr[2]),
    .req_wdata(wdata[2]), .req_ready(rdy[2]), .rsp_valid(vld[2]), .rsp_rdata(rdata[2]),
    .err(err[2]), .acc_cnt(acc[2])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int i, input logic r, input logic w,
                       input logic [14:0] a, input logic [7:0] d);
    rd[i]    = r;
    wr[i]    = w;
    addr[i]  = a;
    wdata[i] = d;
  endtask

  task automatic idle(input int i);
    drive(i, 1'b0, 1'b0, 15'h0, 8'h0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1;
      idle(i);
    end
    tick();
    tick();

    // Reset state on all instances
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_rdy_%0d", i),   32'(rdy[i]),   32'd1);
      chk($sformatf("rst_vld_%0d", i),   32'(vld[i]),   32'd0);
      chk($sformatf("rst_rdata_%0d", i), 32'(rdata[i]), 32'd0);
      chk($sformatf("rst_err_%0d", i),   32'(err[i]),   32'd0);
      chk($sformatf("rst_acc_%0d", i),   32'(acc[i]),   32'd0);
      rst[i] = 1'b0;
    end

    // ---- READ_LAT=2: write 0xA5 to 0x105, read it back the next cycle
    drive(0, 1'b0, 1'b1, 15'h105, 8'hA5);
    tick();
    chk("a_wr_rdy", 32'(rdy[0]), 32'd1);
    chk("a_wr_acc", 32'(acc[0]), 32'd1);
    chk("a_wr_err", 32'(err[0]), 32'd0);
    drive(0, 1'b1, 1'b0, 15'h105, 8'h00);
    tick();
    chk("a_wait_rdy", 32'(rdy[0]), 32'd0);
    chk("a_wait_vld", 32'(vld[0]), 32'd0);
    chk("a_wait_acc", 32'(acc[0]), 32'd2);
    // Write while not ready must be ignored
    drive(0, 1'b0, 1'b1, 15'h105, 8'hFF);
    tick();
    chk("a_rsp_vld", 32'(vld[0]), 32'd1);
    chk("a_rsp_rdata", 32'(rdata[0]), 32'hA5);
    chk("a_rsp_err", 32'(err[0]), 32'd0);
    chk("a_rsp_rdy", 32'(rdy[0]), 32'd0);
    chk("a_rsp_acc", 32'(acc[0]), 32'd2);
    idle(0);
    tick();
    chk("a_post_vld", 32'(vld[0]), 32'd0);
    chk("a_post_hold", 32'(rdata[0]), 32'hA5);
    chk("a_post_rdy", 32'(rdy[0]), 32'd1);
    drive(0, 1'b1, 1'b0, 15'h105, 8'h00);
    tick();
    idle(0);
    tick();
    chk("a_reread_vld", 32'(vld[0]), 32'd1);
    chk("a_reread_rdata", 32'(rdata[0]), 32'hA5);
    chk("a_reread_acc", 32'(acc[0]), 32'd3);
    tick();

    // ---- rd+wr conflict at 0x300: err only, no count, no response
    drive(0, 1'b1, 1'b1, 15'h300, 8'h77);
    tick();
    idle(0);
    chk("conf_err", 32'(err[0]), 32'd1);
    chk("conf_vld", 32'(vld[0]), 32'd0);
    chk("conf_acc", 32'(acc[0]), 32'd3);
    chk("conf_rdy", 32'(rdy[0]), 32'd1);
    tick();
    chk("conf_err_end", 32'(err[0]), 32'd0);
    chk("conf_vld_end", 32'(vld[0]), 32'd0);

    // ---- Out-of-range read at 0x7FFF (DEPTH=16384)
    drive(0, 1'b1, 1'b0, 15'h7FFF, 8'h00);
    tick();
    idle(0);
    chk("oor_rd_acc", 32'(acc[0]), 32'd4);
    chk("oor_rd_err_early", 32'(err[0]), 32'd0);
    tick();
    chk("oor_rd_vld", 32'(vld[0]), 32'd1);
    chk("oor_rd_err", 32'(err[0]), 32'd1);
    chk("oor_rd_rdata", 32'(rdata[0]), 32'd0);
    tick();
    chk("oor_rd_vld_end", 32'(vld[0]), 32'd0);
    chk("oor_rd_err_end", 32'(err[0]), 32'd0);

    // ---- Out-of-range write at 0x4100 must not alias onto 0x0100
    drive(0, 1'b0, 1'b1, 15'h100, 8'h5A);
    tick();
    drive(0, 1'b0, 1'b1, 15'h4100, 8'h99);
    tick();
    idle(0);
    chk("oor_wr_err", 32'(err[0]), 32'd1);
    chk("oor_wr_acc", 32'(acc[0]), 32'd6);
    tick();
    chk("oor_wr_err_end", 32'(err[0]), 32'd0);
    drive(0, 1'b1, 1'b0, 15'h100, 8'h00);
    tick();
    idle(0);
    tick();
    chk("alias_vld", 32'(vld[0]), 32'd1);
    chk("alias_rdata", 32'(rdata[0]), 32'h5A);
    chk("alias_acc", 32'(acc[0]), 32'd7);
    tick();

    // ---- Write 0x3C to 0x0010 (below PROT_LIMIT)
    drive(0, 1'b0, 1'b1, 15'h10, 8'h3C);
    tick();
    idle(0);
`ifdef MISAO_MEM_PROTECT_EN
    chk("prot_wr_err", 32'(err[0]), 32'd1);
`else
    chk("prot_wr_err", 32'(err[0]), 32'd0);
`endif
    chk("prot_wr_acc", 32'(acc[0]), 32'd8);
    tick();
    drive(0, 1'b1, 1'b0, 15'h10, 8'h00);
    tick();
    idle(0);
    tick();
    chk("prot_rd_vld", 32'(vld[0]), 32'd1);
`ifdef MISAO_MEM_PROTECT_EN
    chk("prot_rd_not_new", 32'(rdata[0] == 8'h3C), 32'd0);
`else
    chk("prot_rd_rdata", 32'(rdata[0]), 32'h3C);
`endif
    chk("prot_rd_acc", 32'(acc[0]), 32'd9);
    tick();

    // ---- READ_LAT=1: four back-to-back writes then reads
    for (int k = 0; k < 4; k++) begin
      drive(1, 1'b0, 1'b1, 15'(15'h200 + k), bdat[k]);
      tick();
      chk($sformatf("b_wr_rdy_%0d", k), 32'(rdy[1]), 32'd1);
      chk($sformatf("b_wr_acc_%0d", k), 32'(acc[1]), 32'(k + 1));
    end
    for (int k = 0; k < 4; k++) begin
      drive(1, 1'b1, 1'b0, 15'(15'h200 + k), 8'h00);
      tick();
      idle(1);
      chk($sformatf("b_rd_vld_%0d", k),   32'(vld[1]),   32'd1);
      chk($sformatf("b_rd_rdata_%0d", k), 32'(rdata[1]), 32'(bdat[k]));
      chk($sformatf("b_rd_rdy_%0d", k),   32'(rdy[1]),   32'd0);
      chk($sformatf("b_rd_acc_%0d", k),   32'(acc[1]),   32'(5 + k));
      tick();
      chk($sformatf("b_idle_vld_%0d", k),  32'(vld[1]),   32'd0);
      chk($sformatf("b_idle_rdy_%0d", k),  32'(rdy[1]),   32'd1);
      chk($sformatf("b_idle_hold_%0d", k), 32'(rdata[1]), 32'(bdat[k]));
    end
    // Read on the cycle right after a write to the same address
    drive(1, 1'b0, 1'b1, 15'h210, 8'h66);
    tick();
    drive(1, 1'b1, 1'b0, 15'h210, 8'h00);
    tick();
    idle(1);
    chk("b_raw_vld", 32'(vld[1]), 32'd1);
    chk("b_raw_rdata", 32'(rdata[1]), 32'h66);
    tick();

    // ---- READ_LAT=4: normal read timing
    drive(2, 1'b0, 1'b1, 15'h20, 8'h4D);
    tick();
    drive(2, 1'b1, 1'b0, 15'h20, 8'h00);
    tick();
    idle(2);
    for (int k = 1; k < 4; k++) begin
      chk($sformatf("c_lat_vld_%0d", k), 32'(vld[2]), 32'd0);
      tick();
    end
    chk("c_lat_vld_4", 32'(vld[2]), 32'd1);
    chk("c_lat_rdata", 32'(rdata[2]), 32'h4D);
    tick();
    chk("c_lat_vld_end", 32'(vld[2]), 32'd0);

    // ---- READ_LAT=4: reset one cycle after read accept aborts the read
    drive(2, 1'b1, 1'b0, 15'h20, 8'h00);
    tick();
    idle(2);
    chk("c_abort_rdy_pre", 32'(rdy[2]), 32'd0);
    chk("c_abort_acc_pre", 32'(acc[2]), 32'd3);
    rst[2] = 1'b1;
    #1;
    chk("c_abort_rdy", 32'(rdy[2]), 32'd1);
    chk("c_abort_acc", 32'(acc[2]), 32'd0);
    chk("c_abort_vld", 32'(vld[2]), 32'd0);
    tick();
    rst[2] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("c_after_vld_%0d", k), 32'(vld[2]), 32'd0);
      chk($sformatf("c_after_rdy_%0d", k), 32'(rdy[2]), 32'd1);
    end
    chk("c_after_acc", 32'(acc[2]), 32'd0);

    // ---- acc_cnt wrap after 65536 accepted writes from reset
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    chk("wrap_start", 32'(acc[0]), 32'd0);
    drive(0, 1'b0, 1'b1, 15'h200, 8'h00);
    for (int n = 0; n < 65535; n++) begin
      tick();
    end
    chk("wrap_ffff", 32'(acc[0]), 32'hFFFF);
    tick();
    idle(0);
    chk("wrap_zero", 32'(acc[0]), 32'd0);
    tick();
    chk("wrap_hold", 32'(acc[0]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
